// File: rtl/awg_pkg.sv
// Shared AWG constants: field-select codes, parameter widths and reset values,
// used by both the key controller and the triangle generator.
package awg_pkg;

    localparam int FREQ_W  = 12;
    localparam int AMP_W   = 3;
    localparam int PHASE_W = 8;

    localparam logic [FREQ_W-1:0]  FREQ_RST  = 12'd1;
    localparam logic [AMP_W-1:0]   AMP_RST   = 3'd4;
    localparam logic [PHASE_W-1:0] PHASE_RST = 8'd0;

    localparam int NUM_KEYS = 4;
    localparam int K_MODE   = 0;
    localparam int K_UP     = 1;
    localparam int K_DOWN   = 2;
    localparam int K_RUN    = 3;

    typedef enum logic [1:0] {
        SEL_FREQ  = 2'd0,
        SEL_AMP   = 2'd1,
        SEL_PHASE = 2'd2
    } sel_t;

    // 13-bit arithmetic so a step past either end is detected, then clamped to [1, 4095].
    function automatic logic [FREQ_W-1:0] freq_step(input logic [FREQ_W-1:0] f,
                                                    input logic              up,
                                                    input logic [FREQ_W-1:0] step);
        logic [FREQ_W:0] s;
        s = up ? ({1'b0, f} + {1'b0, step}) : ({1'b0, f} - {1'b0, step});
        if (up)
            freq_step = s[FREQ_W] ? {FREQ_W{1'b1}} : s[FREQ_W-1:0];
        else
            freq_step = (s[FREQ_W] || s == '0) ? FREQ_W'(1) : s[FREQ_W-1:0];
    endfunction

endpackage

// File: rtl/awg_key_ctrl_if.sv
// Front-panel bus: raw active-low keys in, registered generator parameters out.
interface awg_key_ctrl_if;
    import awg_pkg::*;

    logic               key_mode;
    logic               key_up;
    logic               key_down;
    logic               key_run;
    logic               en;
    logic [FREQ_W-1:0]  state_freq;
    logic [AMP_W-1:0]   state_amp;
    logic [PHASE_W-1:0] state_phase;
    logic [1:0]         sel_field;

    modport master (output key_mode, key_up, key_down, key_run,
                    input  en, state_freq, state_amp, state_phase, sel_field);
    modport slave  (input  key_mode, key_up, key_down, key_run,
                    output en, state_freq, state_amp, state_phase, sel_field);
endinterface

// File: rtl/key_debounce.sv
// One push-button: 2-FF synchroniser, stability counter, debounced level and
// a one-cycle press pulse on the debounced 1->0 flip.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key_raw};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // Final stable cycle: flip now so the pulse coincides with the flip.
                cnt   <= '0;
                level <= sync[1];
                press <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/awg_key_ctrl.sv
// AWG front-panel control: debounces four keys and holds en/freq/amp/phase.
// Optional auto-repeat of up/down is built only with AWG_KEY_AUTOREPEAT_EN.
module awg_key_ctrl
    import awg_pkg::*;
#(
    parameter int                 DEBOUNCE_CYCLES = 20000,
    parameter logic [FREQ_W-1:0]  FREQ_STEP       = 12'd1,
    parameter logic [PHASE_W-1:0] PHASE_STEP      = 8'd8,
    parameter int                 REPEAT_DELAY    = 500000,
    parameter int                 REPEAT_PERIOD   = 100000
) (
    input  logic          clk,
    input  logic          rst_n,
    awg_key_ctrl_if.slave bus
);
    if (DEBOUNCE_CYCLES < 2) $error("DEBOUNCE_CYCLES must be at least 2");
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) $error("repeat timing must be at least 1");

    logic [NUM_KEYS-1:0] key_raw, key_lvl, key_press;
    assign key_raw = {bus.key_run, bus.key_down, bus.key_up, bus.key_mode};

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .key_raw (key_raw[g]),
            .level   (key_lvl[g]),
            .press   (key_press[g])
        );
    end

    logic up_ev, dn_ev;

`ifdef AWG_KEY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [1:0][RW-1:0] rpt_cnt;
    logic [1:0]         rpt_armed, rpt_step;

    // Index 0 tracks up, 1 tracks down; the press itself restarts the hold timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt   <= '0;
            rpt_armed <= '0;
            rpt_step  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rpt_step[i] <= 1'b0;
                if (key_lvl[K_UP+i] || key_press[K_UP+i]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_armed[i] <= 1'b0;
                end else if (rpt_cnt[i] == (rpt_armed[i] ? RW'(REPEAT_PERIOD - 1)
                                                         : RW'(REPEAT_DELAY - 1))) begin
                    rpt_cnt[i]   <= '0;
                    rpt_armed[i] <= 1'b1;
                    rpt_step[i]  <= 1'b1;
                end else begin
                    rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign up_ev = key_press[K_UP]   | rpt_step[0];
    assign dn_ev = key_press[K_DOWN] | rpt_step[1];
`else
    assign up_ev = key_press[K_UP];
    assign dn_ev = key_press[K_DOWN];
`endif

    wire mode_ev = key_press[K_MODE];
    wire run_ev  = key_press[K_RUN];
    // Mode wins over an edit in the same cycle; up+down cancel each other.
    wire edit_ev = ~mode_ev & (up_ev ^ dn_ev);

    sel_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SEL_FREQ;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEL_FREQ:  if (mode_ev) state_d = SEL_AMP;
            SEL_AMP:   if (mode_ev) state_d = SEL_PHASE;
            SEL_PHASE: if (mode_ev) state_d = SEL_FREQ;
            default:   state_d = SEL_FREQ;
        endcase
    end

    always_comb begin
        bus.sel_field = state_q;
    end

    logic               en_q;
    logic [FREQ_W-1:0]  freq_q;
    logic [AMP_W-1:0]   amp_q;
    logic [PHASE_W-1:0] phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            freq_q  <= FREQ_RST;
            amp_q   <= AMP_RST;
            phase_q <= PHASE_RST;
        end else begin
            if (run_ev) en_q <= ~en_q;
            if (edit_ev) begin
                case (state_q)
                    SEL_FREQ: freq_q <= freq_step(freq_q, up_ev, FREQ_STEP);
                    SEL_AMP: begin
                        if (up_ev && amp_q != {AMP_W{1'b1}}) amp_q <= amp_q + 1'b1;
                        if (dn_ev && amp_q != '0)            amp_q <= amp_q - 1'b1;
                    end
                    SEL_PHASE: phase_q <= up_ev ? phase_q + PHASE_STEP : phase_q - PHASE_STEP;
                    default: ;
                endcase
            end
        end
    end

    assign bus.en          = en_q;
    assign bus.state_freq  = freq_q;
    assign bus.state_amp   = amp_q;
    assign bus.state_phase = phase_q;
endmodule
